// File: rtl/adder_accumulator_pkg.sv
// Shared types and default sizing for the frame-summing accumulator.
package adder_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEFAULT_N         = 8;
  localparam int DEFAULT_FRAME_LEN = 4;

endpackage

// File: rtl/accum_adder.sv
// Combinational N-bit adder built from a chain of 1-bit full-adder cells.
module accum_adder
  import adder_accumulator_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         carry
);

  // Each cell pulls its carry-in from the previous cell's block, keeping the chain explicit.
  for (genvar gi = 0; gi < N; gi++) begin : g_fa
    logic ci;
    logic co;
    if (gi == 0) begin : g_first
      assign ci = cin;
    end else begin : g_rest
      assign ci = g_fa[gi-1].co;
    end
    assign sum[gi] = a[gi] ^ b[gi] ^ ci;
    assign co      = (a[gi] & b[gi]) | (ci & (a[gi] ^ b[gi]));
  end

  assign carry = g_fa[N-1].co;

endmodule

// File: rtl/adder_accumulator.sv
// Sums FRAME_LEN streamed operands per frame and presents the sum plus a sticky carry flag.
module adder_accumulator
  import adder_accumulator_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_ovf,
  output logic [7:0]   out_frame_cnt
);

  localparam int             CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);

  state_t           state, state_next;
  logic [N-1:0]     acc, acc_next;
  logic             ovf, ovf_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [N-1:0]     out_sum_next;
  logic             out_ovf_next;
  logic [7:0]       out_frame_cnt_next;
  logic [N-1:0]     add_sum;
  logic             add_carry;

  accum_adder #(.N(N)) u_adder (
    .a     (acc),
    .b     (in_data),
    .cin   (1'b0),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Handshake flags decode the registered state only, so in_ready never depends on out_ready.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ACCUM;
      acc           <= '0;
      ovf           <= 1'b0;
      cnt           <= '0;
      out_sum       <= '0;
      out_ovf       <= 1'b0;
      out_frame_cnt <= 8'd0;
    end else begin
      state         <= state_next;
      acc           <= acc_next;
      ovf           <= ovf_next;
      cnt           <= cnt_next;
      out_sum       <= out_sum_next;
      out_ovf       <= out_ovf_next;
      out_frame_cnt <= out_frame_cnt_next;
    end
  end

  always_comb begin
    state_next         = state;
    acc_next           = acc;
    ovf_next           = ovf;
    cnt_next           = cnt;
    out_sum_next       = out_sum;
    out_ovf_next       = out_ovf;
    out_frame_cnt_next = out_frame_cnt;
    case (state)
      ACCUM: begin
        // clr wins over a simultaneous operand, which is dropped.
        if (clr) begin
          acc_next = '0;
          ovf_next = 1'b0;
          cnt_next = '0;
        end else if (in_valid) begin
          acc_next = add_sum;
          ovf_next = ovf | add_carry;
          cnt_next = cnt + CNT_W'(1);
          if (cnt == LAST) begin
            out_sum_next = add_sum;
            out_ovf_next = ovf | add_carry;
            state_next   = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_next           = '0;
          ovf_next           = 1'b0;
          cnt_next           = '0;
          out_frame_cnt_next = out_frame_cnt + 8'd1;
          state_next         = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed checks of the frame accumulator (FRAME_LEN=4 and a FRAME_LEN=1 build).
module tb_adder_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_ovf;
  logic [7:0] out_sum, out_frame_cnt;

  logic       in_valid1, out_ready1;
  logic [7:0] in_data1;
  logic       in_ready1, out_valid1, out_ovf1;
  logic [7:0] out_sum1, out_frame_cnt1;

  int total = 0;
  int bad   = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  adder_accumulator #(.N(8), .FRAME_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .out_frame_cnt(out_frame_cnt)
  );

  adder_accumulator #(.N(8), .FRAME_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_ovf(out_ovf1), .out_frame_cnt(out_frame_cnt1)
  );

  typedef struct {
    logic [7:0] d0, d1, d2, d3;
    logic [7:0] exp_sum;
    logic       exp_ovf;
  } frame_vec_t;

  frame_vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic feed(input logic [7:0] v);
    @(negedge clk);
    chk("in_ready_before_feed", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = v;
  endtask

  // Sample the cycle after the last accept: result must be presented there.
  task automatic check_result(input string tag, input logic [7:0] es, input logic eo);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_out_sum"},   32'(out_sum),   32'(es));
    chk({tag, "_out_ovf"},   32'(out_ovf),   32'(eo));
    $display("frame %s: sum=%0d ovf=%0d", tag, out_sum, out_ovf);
  endtask

  task automatic check_consumed(input string tag);
    @(negedge clk);
    chk({tag, "_cons_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_cons_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_frame_cnt"},      32'(out_frame_cnt), 32'(exp_frames));
  endtask

  initial begin
    vecs[0] = '{d0:8'd1,   d1:8'd2,   d2:8'd3,   d3:8'd4,   exp_sum:8'd10,  exp_ovf:1'b0};
    vecs[1] = '{d0:8'd200, d1:8'd100, d2:8'd0,   d3:8'd0,   exp_sum:8'd44,  exp_ovf:1'b1};
    vecs[2] = '{d0:8'd255, d1:8'd255, d2:8'd255, d3:8'd255, exp_sum:8'd252, exp_ovf:1'b1};
    vecs[3] = '{d0:8'd1,   d1:8'd1,   d2:8'd1,   d3:8'd1,   exp_sum:8'd4,   exp_ovf:1'b0};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = 8'd0; out_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_out_ovf",   32'(out_ovf),   32'd0);
    chk("rst_frame_cnt", 32'(out_frame_cnt), 32'd0);
    rst_n = 1'b1;

    // Table-driven frames, consumer always ready.
    for (int i = 0; i < 4; i++) begin
      feed(vecs[i].d0); feed(vecs[i].d1); feed(vecs[i].d2); feed(vecs[i].d3);
      check_result($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_ovf);
      exp_frames++;
      check_consumed($sformatf("vec%0d", i));
    end

    // Backpressure: result held while out_ready is low, input ignored.
    out_ready = 1'b0;
    feed(8'd10); feed(8'd20); feed(8'd30); feed(8'd40);
    check_result("bp", 8'd100, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(1, 255));
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_sum",   32'(out_sum),   32'd100);
      chk("bp_hold_ovf",   32'(out_ovf),   32'd0);
      chk("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exp_frames++;
    check_consumed("bp");

    // Abort mid-frame; the operand presented with clr is dropped.
    feed(8'd7); feed(8'd9);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'd50;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    feed(8'd1); feed(8'd1); feed(8'd1); feed(8'd1);
    check_result("abort", 8'd4, 1'b0);
    exp_frames++;
    check_consumed("abort");

    // clr during HOLD must not disturb the pending result.
    out_ready = 1'b0;
    feed(8'd3); feed(8'd3); feed(8'd3); feed(8'd3);
    check_result("hclr", 8'd12, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("hclr_valid", 32'(out_valid), 32'd1);
    chk("hclr_sum",   32'(out_sum),   32'd12);
    out_ready = 1'b1;
    exp_frames++;
    check_consumed("hclr");

    // Asynchronous reset mid-frame, asserted between clock edges.
    feed(8'd2); feed(8'd3);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_sum",   32'(out_sum),   32'd0);
    chk("arst_out_ovf",   32'(out_ovf),   32'd0);
    chk("arst_frame_cnt", 32'(out_frame_cnt), 32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_frames = 0;
    feed(8'd5); feed(8'd5); feed(8'd5); feed(8'd5);
    check_result("post_rst", 8'd20, 1'b0);
    exp_frames++;
    check_consumed("post_rst");

    // FRAME_LEN=1 build: each operand is its own frame.
    @(negedge clk);
    in_valid1 = 1'b1; in_data1 = 8'hFF;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("f1a_valid", 32'(out_valid1), 32'd1);
    chk("f1a_sum",   32'(out_sum1),   32'hFF);
    chk("f1a_ovf",   32'(out_ovf1),   32'd0);
    $display("frame f1a: sum=%0d ovf=%0d", out_sum1, out_ovf1);
    @(negedge clk);
    chk("f1a_ready", 32'(in_ready1), 32'd1);
    in_valid1 = 1'b1; in_data1 = 8'h01;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("f1b_valid", 32'(out_valid1), 32'd1);
    chk("f1b_sum",   32'(out_sum1),   32'h01);
    chk("f1b_ovf",   32'(out_ovf1),   32'd0);
    $display("frame f1b: sum=%0d ovf=%0d", out_sum1, out_ovf1);
    @(negedge clk);
    chk("f1_frame_cnt", 32'(out_frame_cnt1), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
